// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a run of sequential words from the single-port
// RAM and presents them as a valid/ready stream. Reads are only issued when
// there is guaranteed room for the returning word in the small output FIFO.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_length,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic                  o_ram_oe,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  inflight;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  start_go;
    logic [OW-1:0]         credit_used;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A word is in flight when a read was issued last cycle; credits count
    // buffered plus in-flight words, less the one leaving this cycle.
    assign push        = inflight;
    assign pop         = (count != '0) & i_ready;
    assign credit_used = OW'(count) + OW'(inflight) - OW'(pop);
    assign issue       = (state == READ) && (credit_used < OW'(FIFO_DEPTH));
    assign start_go    = (state == IDLE) && i_start && (i_length != '0);

    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);
    assign o_ram_oe      = (state == READ) || (state == DRAIN);
    assign o_ram_we      = 1'b0;
    assign o_ram_address = addr;
    assign o_valid       = (count != '0);
    assign o_data        = fifo_mem[rd_ptr];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: drain finishes once nothing is in flight and the last
    // buffered word is leaving, so done follows the final pop directly.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) state_next = (i_length == '0) ? DONE : READ;
            end
            READ: begin
                if (issue && (remaining == (ADDR_WIDTH+1)'(1))) state_next = DRAIN;
            end
            DRAIN: begin
                if (!inflight && (count == CW'(pop))) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/remaining bookkeeping and the one-cycle read-latency tracker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (start_go) begin
                addr      <= i_base_addr;
                remaining <= i_length;
            end else if (issue) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Output FIFO; the credit check means a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= i_ram_data;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: a behavioural RAM with one-cycle read
// latency, and an expected-word queue built from base/length arithmetic.
module tb_ram_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_base_addr;
    logic [8:0] i_length;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_ram_address;
    logic       o_ram_oe;
    logic       o_ram_we;
    logic [7:0] i_ram_data;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    logic [7:0] mem [256];
    int         checks;
    int         failures;

    ram_stream_reader #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_base_addr(i_base_addr),
        .i_length(i_length),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_ram_address(o_ram_address),
        .o_ram_oe(o_ram_oe),
        .o_ram_we(o_ram_we),
        .i_ram_data(i_ram_data),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: a read issued in one cycle returns data in the next.
    always @(posedge clk) begin
        if (o_ram_oe) i_ram_data <= mem[o_ram_address];
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic [7:0] base, input logic [8:0] len);
        i_start     = start;
        i_base_addr = base;
        i_length    = len;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one burst; mode 0 ready always, 1 fixed toggle pattern, 2 random.
    // A nonzero abort_after returns right after that many words were popped.
    task automatic runBurst(input logic [7:0] base, input int len, input int mode, input int abort_after,
                            output int first_valid, output int last_pop, output int done_cycle, output int popped);
        logic [7:0] exp_q[$];
        logic [5:0] pat;
        int         budget;
        bit         finished;
        pat         = 6'b101001;
        first_valid = -1;
        last_pop    = -1;
        done_cycle  = -1;
        popped      = 0;
        finished    = 0;
        budget      = len * 8 + 20;
        for (int k = 0; k < len; k++) exp_q.push_back(mem[8'(int'(base) + k)]);
        applyStimulus(1'b1, base, 9'(len));
        tick();
        applyStimulus(1'b0, 8'h00, 9'h000);
        checkOutput("ram_we_zero", {31'd0, o_ram_we}, 32'd0);
        for (int c = 0; c < budget && !finished; c++) begin
            if (o_done) begin
                done_cycle = c;
                checkOutput("done_busy", {31'd0, o_busy}, 32'd1);
                checkOutput("done_queue_empty", exp_q.size(), 32'd0);
                finished = 1;
            end else begin
                case (mode)
                    0:       i_ready = 1'b1;
                    1:       i_ready = pat[c % 6];
                    default: i_ready = 1'($urandom_range(0, 1));
                endcase
                if (o_valid) begin
                    if (first_valid < 0) first_valid = c;
                    if (exp_q.size() == 0) checkOutput("extra_word", 32'd1, 32'd0);
                    else                   checkOutput("stream_data", {24'd0, o_data}, {24'd0, exp_q[0]});
                end
                if (o_valid && i_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    popped++;
                    last_pop = c;
                end
                tick();
                if (abort_after != 0 && popped == abort_after) finished = 1;
            end
        end
        if (!finished) checkOutput("burst_timeout", 32'd0, 32'd1);
    endtask

    // Common end-of-burst checks: every word once, done right after last pop.
    task automatic finishBurst(input int len, input int last_pop, input int done_cycle, input int popped);
        checkOutput("word_count", popped, len);
        checkOutput("done_after_last_pop", done_cycle, last_pop + 1);
        tick();
        checkOutput("busy_falls", {31'd0, o_busy}, 32'd0);
        checkOutput("done_one_cycle", {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        int fv, lp, dc, np;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_ready  = 1'b0;
        applyStimulus(1'b0, 8'h00, 9'h000);
        for (int k = 0; k < 256; k++) mem[k] = 8'(k + 8'h10);

        $display("[TB] reset state");
        tick();
        tick();
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_done", {31'd0, o_done}, 32'd0);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_oe", {31'd0, o_ram_oe}, 32'd0);
        checkOutput("rst_addr", {24'd0, o_ram_address}, 32'd0);
        checkOutput("rst_data", {24'd0, o_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic burst base=4 length=3");
        runBurst(8'h04, 3, 0, 0, fv, lp, dc, np);
        checkOutput("first_valid_latency", fv, 32'd2);
        checkOutput("last_pop_cycle", lp, 32'd4);
        finishBurst(3, lp, dc, np);

        $display("[TB] address wrap base=FE length=4");
        runBurst(8'hFE, 4, 0, 0, fv, lp, dc, np);
        finishBurst(4, lp, dc, np);

        $display("[TB] backpressure length=6");
        runBurst(8'h20, 6, 1, 0, fv, lp, dc, np);
        finishBurst(6, lp, dc, np);

        $display("[TB] zero length with ignored restart");
        applyStimulus(1'b1, 8'h33, 9'h000);
        tick();
        checkOutput("zero_done", {31'd0, o_done}, 32'd1);
        checkOutput("zero_busy", {31'd0, o_busy}, 32'd1);
        checkOutput("zero_oe", {31'd0, o_ram_oe}, 32'd0);
        applyStimulus(1'b1, 8'h05, 9'h003);
        tick();
        checkOutput("restart_ignored_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("restart_ignored_done", {31'd0, o_done}, 32'd0);
        checkOutput("restart_ignored_oe", {31'd0, o_ram_oe}, 32'd0);
        applyStimulus(1'b0, 8'h00, 9'h000);
        tick();
        checkOutput("idle_after_zero_oe", {31'd0, o_ram_oe}, 32'd0);
        checkOutput("idle_after_zero_busy", {31'd0, o_busy}, 32'd0);

        $display("[TB] mid-burst reset");
        runBurst(8'h40, 10, 0, 4, fv, lp, dc, np);
        checkOutput("abort_popped", np, 32'd4);
        rst_n = 1'b0;
        tick();
        checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("abort_done", {31'd0, o_done}, 32'd0);
        checkOutput("abort_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("abort_oe", {31'd0, o_ram_oe}, 32'd0);
        checkOutput("abort_addr", {24'd0, o_ram_address}, 32'd0);
        checkOutput("abort_data", {24'd0, o_data}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("abort_no_done", {31'd0, o_done}, 32'd0);
        runBurst(8'h00, 2, 0, 0, fv, lp, dc, np);
        finishBurst(2, lp, dc, np);

        $display("[TB] full depth length=256");
        runBurst(8'h00, 256, 0, 0, fv, lp, dc, np);
        finishBurst(256, lp, dc, np);

        $display("[TB] randomized bursts");
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        for (int r = 0; r < 6; r++) begin
            runBurst(8'($urandom), int'($urandom_range(1, 24)), 2, 0, fv, lp, dc, np);
            checkOutput("rand_done_seen", (dc >= 0) ? 32'd1 : 32'd0, 32'd1);
            checkOutput("rand_word_count_ok", (np > 0) ? 32'd1 : 32'd0, 32'd1);
            tick();
            checkOutput("rand_idle", {31'd0, o_busy}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
